cordic_arbiter: RTL
===================

# cordic_arbiter

Round-robin scheduler that shares one serial `cordicCosSin` core between `N_REQ` requesters. It accepts phase requests and issues them to the core one at a time with an `st` pulse. It tracks core busy through `rdy` and returns each `cos`/`sin` pair tagged with the originating requester index. It sits between the NCO/mixer clients and the single CORDIC instance.

## Interface
- `N_REQ`, 4, number of requesters (2..16).
- `PHI_WDT`, 16, phase/result width; must match the core.
- `TIMEOUT`, 64, max BUSY cycles before abort; only used with the macro.
- `ID_WDT`, localparam `$clog2(N_REQ)`.
- Ports:
  - `clk`  in  1  clock.
  - `reset`  in  1  synchronous, active-high reset.
  - `sclr`  in  1  synchronous clear; same effect as `reset`.
  - `en`  in  1  clock enable; state frozen and pulse outputs 0 while low.
  - `req`  in  N_REQ  request level per requester.
  - `phi_in`  in  N_REQ*PHI_WDT  flattened phases; slice i belongs to `req[i]`.
  - `ack`  out  N_REQ  one-hot, 1-cycle pulse: request i accepted and phase sampled.
  - `vld`  out  1  1-cycle pulse: `cos`/`sin`/`id` valid.
  - `id`  out  ID_WDT  requester index of the result.
  - `cos`, `sin`  out  PHI_WDT  signed results; held until next `vld`.
  - `busy`  out  1  high when state ≠ IDLE.
  - `err`  out  1  timeout pulse (macro only).
  - `cordic_st`, `cordic_phi`, `cordic_sclr`, `cordic_en`  out  core controls.
  - `cordic_rdy`, `cordic_cos`, `cordic_sin`  in  core status and results.

## Operation
- FSM states:
  - IDLE: if `|req`, pick a winner round-robin, starting from the index after the last grant. Register `ack[w]`, `cordic_st`, `cordic_phi=phi_in[w]`, `gnt_id=w`; go to BUSY. With no request, stay in IDLE.
  - BUSY: the first cycle (the one carrying `cordic_st`) ignores `cordic_rdy`. From the second cycle on, `cordic_rdy=1` captures `cordic_cos`/`cordic_sin` and goes to DONE.
  - DONE: `vld=1`, `id=gnt_id`; go to IDLE.
- Pointer update: the last-grant pointer takes the value `w` on grant.
- Requesters:
  - `req` is sampled only in IDLE.
  - `phi_in[i]` must be stable while `req[i]` is high.
  - A `req[i]` still high in the IDLE after its ack is a new request.
- `cordic_en = en`. `cordic_sclr = sclr | reset | timeout_abort`.
- Reset/sclr, including mid-operation:
  - state IDLE; pointer = N_REQ-1, so index 0 wins first.
  - all outputs 0.
  - the in-flight result is discarded and no `vld` is issued.
- Simultaneous `sclr` with `cordic_rdy` in BUSY: `sclr` wins and no `vld` is issued.
- `en=0`: no state, counter or pointer change. `ack`, `cordic_st`, `vld` and `err` are 0. Registered data holds.
- No arithmetic on data; results pass through bit-exact.

## Timing
- Cycle 0: `req[i]` high in IDLE.
- Cycle 1: `ack[i]=1`, `cordic_st=1`, `cordic_phi` valid; state BUSY.
- The core drops `rdy` from cycle 2. If it raises `rdy` at cycle R, then `vld` is at cycle R+1 and IDLE is at R+1.
- The earliest next `ack` is at R+2.
- Throughput: one transaction per core latency + 3 cycles.
- `ack` and `vld` are never high for the same requester in the same cycle.
- `ack` is at most one-hot per cycle.

## Configuration
- `CORDIC_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter runs from the `st` cycle.
  - If it reaches `TIMEOUT` without `cordic_rdy`, then for one cycle `err=1`, `id=gnt_id` and `cordic_sclr=1`.
  - No `vld` is issued; state returns to IDLE.
- Undefined:
  - There is no counter, `err` is tied 0 and the block waits indefinitely.
  - `TIMEOUT` is ignored.

## Structure
- `cordic_arb_pkg`: state enum (IDLE, BUSY, DONE) and default parameter constants.
- Sub-module `rr_picker`:
  - combinational round-robin winner search.
  - inputs: `req` and pointer; outputs: `found` and index `w`.
  - instantiated once.
- A core model drives `cordic_rdy` low for L cycles after `st`, then returns `cos = phi`, `sin = ~phi`.

## Test plan
- Single request: `req=4'b0100`, `phi_in[2]=16'h1234`, L=16.
  - `ack=4'b0100` at cycle 1.
  - `vld` at cycle 19 with `id=2`, `cos=16'h1234`, `sin=16'hEDCB`.
- All four requests held high continuously: grants in order 0,1,2,3,0; each `id` matches; no starvation.
- Reset: assert `reset` in BUSY cycle 5.
  - Next cycle: all outputs 0 and `cordic_sclr=1`.
  - No `vld`; the next grant goes to requester 0.
- `en` low for 7 cycles during BUSY: the `vld` cycle shifts by exactly 7, and no pulses occur while `en` is low.
- With `CORDIC_ARB_TIMEOUT_EN`, `TIMEOUT=64`, and a core that never raises `rdy`:
  - `err` pulses at BUSY cycle 64 with `cordic_sclr=1`.
  - No `vld`, and the next request is served normally.
- `req[1]` held through its own ack (other requests high): after DONE, requester 1 does not win again until 2, 3 and 0 have been served.

Source files
------------

// File: rtl/cordic_arbiter_pkg.sv
// Shared types and default parameters for the round-robin CORDIC arbiter.
// The optional BUSY watchdog is controlled by the macro CORDIC_ARB_TIMEOUT_EN.
package cordic_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int PHI_WDT_DEF = 16;
    localparam int TIMEOUT_DEF = 64;

    // DONE is the result step. It is registered on the BUSY->IDLE edge, so the
    // vld cycle is also the first IDLE cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_arbiter_rr_picker.sv
// Combinational round-robin search: the first requester after ptr, wrapping
// around, wins.
module rr_picker #(
    parameter int N_REQ  = 4,
    parameter int ID_WDT = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [ID_WDT-1:0] ptr,
    output logic              found,
    output logic [ID_WDT-1:0] w
);

    always_comb begin
        found = 1'b0;
        w     = '0;
        // The farthest candidate is scanned first, so the nearest one overrides it.
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                found = 1'b1;
                w     = ID_WDT'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler that shares one serial cordicCosSin core between N_REQ
// requesters. Define CORDIC_ARB_TIMEOUT_EN to enable the BUSY watchdog (err pulse).
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int  N_REQ   = N_REQ_DEF,
    parameter int  PHI_WDT = PHI_WDT_DEF,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int ID_WDT  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclr,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*PHI_WDT-1:0] phi_in,
    output logic [N_REQ-1:0]         ack,
    output logic                     vld,
    output logic [ID_WDT-1:0]        id,
    output logic [PHI_WDT-1:0]       cos,
    output logic [PHI_WDT-1:0]       sin,
    output logic                     busy,
    output logic                     err,
    output logic                     cordic_st,
    output logic [PHI_WDT-1:0]       cordic_phi,
    output logic                     cordic_sclr,
    output logic                     cordic_en,
    input  logic                     cordic_rdy,
    input  logic [PHI_WDT-1:0]       cordic_cos,
    input  logic [PHI_WDT-1:0]       cordic_sin,
    output state_t                   state_dbg
);

    state_t              state, state_n;
    logic [ID_WDT-1:0]   ptr, gnt_id, w, id_q;
    logic                found, grant, capture, abort, timeout_hit;
    logic [N_REQ-1:0]    ack_q;
    logic                st_q, vld_q, err_q;
    logic [PHI_WDT-1:0]  phi_q, cos_q, sin_q;

    rr_picker #(.N_REQ(N_REQ), .ID_WDT(ID_WDT)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .w     (w)
    );

    // st_q is still high in the first BUSY cycle, and rdy is not trusted in that cycle.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        if (en) begin
            case (state)
                IDLE: if (found) begin
                    state_n = BUSY;
                    grant   = 1'b1;
                end
                BUSY: if (cordic_rdy && !st_q) begin
                    state_n = IDLE;
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || sclr) state <= IDLE;
        else               state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            ptr    <= ID_WDT'(N_REQ - 1);
            gnt_id <= '0;
            id_q   <= '0;
            ack_q  <= '0;
            st_q   <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            phi_q  <= '0;
            cos_q  <= '0;
            sin_q  <= '0;
        end else if (en) begin
            // Each pulse lasts exactly one enabled cycle and is held while en is low.
            ack_q <= grant ? (N_REQ'(1) << w) : '0;
            st_q  <= grant;
            vld_q <= capture;
            err_q <= abort;
            if (grant) begin
                ptr    <= w;
                gnt_id <= w;
                phi_q  <= phi_in[int'(w)*PHI_WDT +: PHI_WDT];
            end
            if (capture) begin
                cos_q <= cordic_cos;
                sin_q <= cordic_sin;
            end
            if (capture || abort) id_q <= gnt_id;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // The counter reads 1 in the st cycle, so err lands on BUSY cycle TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset || sclr)      cnt <= '0;
        else if (en && grant)   cnt <= CNT_W'(1);
        else if (en && state == BUSY) cnt <= cnt + CNT_W'(1);
    end

    assign timeout_hit = (state == BUSY) && (cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    assign ack         = ack_q & {N_REQ{en}};
    assign cordic_st   = st_q & en;
    assign vld         = vld_q & en;
    assign err         = err_q & en;
    assign id          = id_q;
    assign cos         = cos_q;
    assign sin         = sin_q;
    assign cordic_phi  = phi_q;
    assign busy        = (state != IDLE);
    assign cordic_en   = en;
    assign cordic_sclr = sclr | reset | err;
    assign state_dbg   = state;

endmodule
